// File: rtl/ov7670_sccb_sender_pkg.sv
// Shared types and constants for the OV7670 SCCB write path.
// Used by the command sender and its quarter-bit divider.
package ov7670_pkg;

    typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP, DELAY} sccb_state_t;

    localparam logic [7:0]  OV7670_WRITE_ID = 8'h42;
    localparam logic [15:0] CMD_END         = 16'hFFFF;
    localparam logic [15:0] CMD_DELAY       = 16'hFFF0;
    localparam int unsigned SCCB_FRAME_BITS = 27;

    // Three-phase write frame; each phase ends with a released don't-care bit.
    function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(input logic [7:0]  id,
                                                              input logic [15:0] cmd);
        return {id, 1'b1, cmd[15:8], 1'b1, cmd[7:0], 1'b1};
    endfunction

endpackage

// File: rtl/ov7670_sccb_sender_quarter_tick.sv
// Quarter-bit timebase for the SCCB sender: one-cycle tick every CLK_DIV
// cycles while run is high, counter held at zero otherwise.
module sccb_quarter_tick #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/ov7670_sccb_sender.sv
// SCCB three-phase write master for the OV7670: takes {addr,value} commands
// via send/taken and drives SIOC/SIOD (open drain) one frame at a time.
module ov7670_sccb_sender
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 125,
    parameter logic [7:0]  DEV_ID       = OV7670_WRITE_ID,
    parameter int unsigned GAP_QUARTERS = 8,
    parameter int unsigned DELAY_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] command,
    output logic        ready,
    output logic        taken,
    output logic        sioc,
    output logic        siod_oe
);

    localparam int unsigned GW = (GAP_QUARTERS > 1) ? $clog2(GAP_QUARTERS) : 1;
    localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_QUARTERS - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CYCLES - 1);
    localparam logic [4:0]    BIT_TOP  = 5'(SCCB_FRAME_BITS - 1);

    sccb_state_t                state;
    logic [1:0]                 qtr;
    logic [4:0]                 bit_cnt;
    logic [GW-1:0]              gap_cnt;
    logic [DW-1:0]              dly_cnt;
    logic [SCCB_FRAME_BITS-1:0] shreg;
    logic                       run;
    logic                       tick;

    assign run = (state == START) || (state == BITS) || (state == STOP) || (state == GAP);

    sccb_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Pad levels are assigned on the edge that enters each quarter, so they are
    // already valid for the whole quarter they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            taken   <= 1'b0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
            qtr     <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            dly_cnt <= '0;
            shreg   <= '1;
        end else begin
            taken <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send && ready) begin
                        if (command == CMD_DELAY) begin
                            state   <= DELAY;
                            taken   <= 1'b1;
                            ready   <= 1'b0;
                            dly_cnt <= '0;
                        end else if (command != CMD_END) begin
                            state   <= START;
                            taken   <= 1'b1;
                            ready   <= 1'b0;
                            shreg   <= sccb_frame(DEV_ID, command);
                            qtr     <= '0;
                            sioc    <= 1'b1;
                            siod_oe <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (qtr == 2'd0) begin
                            qtr     <= 2'd1;
                            sioc    <= 1'b0;
                            siod_oe <= 1'b1;
                        end else begin
                            state   <= BITS;
                            qtr     <= 2'd0;
                            bit_cnt <= BIT_TOP;
                            sioc    <= 1'b0;
                            siod_oe <= ~shreg[SCCB_FRAME_BITS-1];
                        end
                    end
                end
                BITS: begin
                    if (tick) begin
                        unique case (qtr)
                            2'd0: begin
                                qtr  <= 2'd1;
                                sioc <= 1'b0;
                            end
                            2'd1: begin
                                qtr  <= 2'd2;
                                sioc <= 1'b1;
                            end
                            2'd2: begin
                                qtr  <= 2'd3;
                                sioc <= 1'b1;
                            end
                            default: begin
                                qtr  <= 2'd0;
                                sioc <= 1'b0;
                                if (bit_cnt == 5'd0) begin
                                    state   <= STOP;
                                    siod_oe <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt - 1'b1;
                                    shreg   <= {shreg[SCCB_FRAME_BITS-2:0], 1'b1};
                                    siod_oe <= ~shreg[SCCB_FRAME_BITS-2];
                                end
                            end
                        endcase
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (qtr == 2'd0) begin
                            qtr     <= 2'd1;
                            sioc    <= 1'b1;
                            siod_oe <= 1'b1;
                        end else if (qtr == 2'd1) begin
                            qtr     <= 2'd2;
                            sioc    <= 1'b1;
                            siod_oe <= 1'b0;
                        end else begin
                            state   <= GAP;
                            qtr     <= 2'd0;
                            gap_cnt <= '0;
                            sioc    <= 1'b1;
                            siod_oe <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// Directed/random bench for ov7670_sccb_sender: a bus monitor decodes
// START/bits/STOP from the pads and frames are compared to arithmetic expectations.
module tb_ov7670_sccb_sender;

    localparam int CD  = 2;
    localparam int GQ  = 1;
    localparam int DLY = 50;
    localparam int FRAME_LAT = (2 + 27 * 4 + 3 + GQ) * CD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send = 1'b0;
    logic [15:0] command = 16'h0000;
    logic        ready, taken, sioc, siod_oe;

    int errors = 0;
    int checks = 0;

    ov7670_sccb_sender #(
        .CLK_DIV      (CD),
        .DEV_ID       (8'h42),
        .GAP_QUARTERS (GQ),
        .DELAY_CYCLES (DLY)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .command (command),
        .ready   (ready),
        .taken   (taken),
        .sioc    (sioc),
        .siod_oe (siod_oe)
    );

    always #5 clk = ~clk;

    // Pad-level monitor: SDA is pulled up when released.
    logic [31:0] fq[$];
    int          nq[$];
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    logic [31:0] cap = '0;
    int          ncap = 0;
    bit          in_frame = 1'b0;

    always @(negedge clk) begin
        logic scl, sda;
        scl = sioc;
        sda = (siod_oe === 1'b1) ? 1'b0 : 1'b1;
        if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda && !sda) begin
            in_frame = 1'b1;
            cap = '0;
            ncap = 0;
        end else if (scl === 1'b1 && prev_scl === 1'b1 && !prev_sda && sda) begin
            if (in_frame) begin
                fq.push_back(cap);
                nq.push_back(ncap);
            end
            in_frame = 1'b0;
        end else if (scl === 1'b1 && prev_scl === 1'b0 && in_frame) begin
            cap = {cap[30:0], sda};
            ncap++;
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected 27-bit frame: id[26:19], dc[18], addr[17:10], dc[9], value[8:1], dc[0].
    function automatic logic [31:0] expected_frame(input logic [15:0] cmd);
        logic [31:0] a, v;
        a = {24'h0, cmd[15:8]};
        v = {24'h0, cmd[7:0]};
        return (32'h42 << 19) + (32'd1 << 18) + (a << 10) + (32'd1 << 9) + (v << 1) + 32'd1;
    endfunction

    // The STOP's SCL rise captures one extra (low) bit before SDA rises.
    task automatic check_frame(input string tag, input logic [15:0] cmd);
        logic [31:0] c;
        int n;
        check({tag, "_frame_present"}, (fq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (fq.size() > 0) begin
            c = fq.pop_front();
            n = nq.pop_front();
            check({tag, "_nbits"}, n, 28);
            check({tag, "_bits"}, c >> 1, expected_frame(cmd));
        end
    endtask

    // Entered just after a posedge with ready=1. lat counts edges from accept to ready.
    task automatic do_frame(input logic [15:0] cmd, input int pulse_at, input logic [15:0] other,
                            output int lat, output int ntk, output int tk_lat, output int busy);
        send = 1'b1;
        command = cmd;
        @(posedge clk); #1;
        send = 1'b0;
        lat = 0; ntk = 0; tk_lat = -1; busy = 0;
        while (lat < 2000) begin
            @(negedge clk);
            if (taken === 1'b1) begin
                ntk++;
                if (tk_lat < 0) tk_lat = lat;
            end
            if (sioc !== 1'b1 || siod_oe !== 1'b0) busy++;
            if (ready === 1'b1) break;
            @(posedge clk); #1;
            lat++;
            send = (lat == pulse_at);
            if (send) command = other;
        end
        send = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, ntk, tk_lat, busy, bad_tk, bad_sioc, bad_oe, bad_rdy, idx;
        bit done;
        logic [15:0] cmd, other;
        logic [15:0] tbl [4];

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_taken", taken, 0);
        check("rst_sioc", sioc, 1);
        check("rst_siod_oe", siod_oe, 0);
        @(posedge clk); #1;

        do_frame(16'h1280, -1, 16'h0, lat, ntk, tk_lat, busy);
        check("f1280_latency", lat, FRAME_LAT);
        check("f1280_ntaken", ntk, 1);
        check("f1280_taken_at", tk_lat, 0);
        check_frame("f1280", 16'h1280);

        // Random commands, each with a stray send pulse while busy.
        for (int i = 0; i < 4; i++) begin
            cmd = 16'($urandom);
            if (cmd >= 16'hFFF0) cmd = cmd ^ 16'h8000;
            other = 16'($urandom);
            do_frame(cmd, int'($urandom_range(5, 200)), other, lat, ntk, tk_lat, busy);
            check("rnd_latency", lat, FRAME_LAT);
            check("rnd_ntaken", ntk, 1);
            check_frame("rnd", cmd);
        end

        // Back-to-back: table advances on taken, send held high throughout.
        tbl = '{16'h1280, 16'h1200, 16'h1100, 16'hFFFF};
        idx = 0; ntk = 0; done = 1'b0;
        command = tbl[0];
        send = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (taken === 1'b1) begin
                ntk++;
                if (idx < 3) idx++;
                command = tbl[idx];
            end
            if (idx == 3 && ready === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        send = 1'b0;
        @(posedge clk); #1;
        check("b2b_done", done, 1);
        check("b2b_ntaken", ntk, 3);
        check_frame("b2b0", 16'h1280);
        check_frame("b2b1", 16'h1200);
        check_frame("b2b2", 16'h1100);
        check("b2b_no_extra", fq.size(), 0);

        // CMD_END held: nothing happens.
        bad_tk = 0; bad_sioc = 0; bad_oe = 0; bad_rdy = 0;
        send = 1'b1;
        command = 16'hFFFF;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (taken !== 1'b0) bad_tk++;
            if (sioc !== 1'b1) bad_sioc++;
            if (siod_oe !== 1'b0) bad_oe++;
            if (ready !== 1'b1) bad_rdy++;
        end
        @(posedge clk); #1;
        send = 1'b0;
        check("end_taken", bad_tk, 0);
        check("end_sioc", bad_sioc, 0);
        check("end_siod_oe", bad_oe, 0);
        check("end_ready", bad_rdy, 0);

        do_frame(16'hFFF0, -1, 16'h0, lat, ntk, tk_lat, busy);
        check("dly_latency", lat, DLY);
        check("dly_ntaken", ntk, 1);
        check("dly_taken_at", tk_lat, 0);
        check("dly_bus_busy", busy, 0);
        check("dly_no_frame", fq.size(), 0);

        // Reset in the middle of bit 10 of the frame (bit 26 is sent first).
        send = 1'b1;
        command = 16'h5A5A;
        @(posedge clk); #1;
        send = 1'b0;
        repeat (134) @(posedge clk);
        @(negedge clk);
        check("mid_busy", ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_sioc", sioc, 1);
        check("abort_siod_oe", siod_oe, 0);
        check("abort_ready", ready, 1);
        check("abort_taken", taken, 0);
        fq.delete();
        nq.delete();
        @(posedge clk); #1;
        do_frame(16'h3A14, -1, 16'h0, lat, ntk, tk_lat, busy);
        check("f3a14_latency", lat, FRAME_LAT);
        check("f3a14_ntaken", ntk, 1);
        check_frame("f3a14", 16'h3A14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
